// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the byte-serial instruction loader.
package inst_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_IDX_W     = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      FLUSH = 3'd3,
      RUN   = 3'd4
   } state_t;

endpackage

// File: rtl/inst_loader_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with a rising-edge
// pulse derived from the synchronized level.
module sync_edge
   import inst_loader_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the pin through the synchronizer chain and remember the last level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;

endmodule

// File: rtl/inst_loader.sv
// Byte-serial instruction loader: assembles pin bytes little-endian into
// 32-bit words, writes them to consecutive instruction-memory addresses and
// holds the CPU in reset while a load session is active.
// Optional feature macro: INST_LOADER_CHECKSUM_EN (running XOR of bytes).
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_mode,
   input  logic              byte_strobe,
   input  logic [7:0]        byte_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst_n,
   output logic [ADDR_W:0]   word_count,
   output logic              overflow,
   output logic [7:0]        checksum
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   state_t                  state;
   state_t                  next_state;
   logic                    load_lvl;
   logic                    load_rise;
   logic                    strobe_lvl;
   logic                    strobe_rise;
   logic [BYTE_IDX_W-1:0]   byte_idx;
   logic [31:0]             asm_q;
   logic [31:0]             word_next;
   logic [ADDR_W:0]         ptr;
   logic                    capture;
   logic                    last_byte;
   logic                    full;
   logic                    enter_load;
   logic                    emit;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (load_mode),
      .level (load_lvl),
      .rise  (load_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (byte_strobe),
      .level (strobe_lvl),
      .rise  (strobe_rise)
   );

   assign capture    = (state == LOAD) && strobe_rise && strobe_lvl;
   assign last_byte  = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
   assign full       = (ptr >= DEPTH_CNT);
   assign enter_load = ((state == IDLE) || (state == RUN)) && (next_state == LOAD);
   assign emit       = (state == LOAD) && ((next_state == WRITE) || (next_state == FLUSH));
   assign word_count = ptr;

   // Assembled word including the byte being captured this cycle.
   always_comb begin
      word_next = asm_q;
      if (capture) begin
         word_next[{byte_idx, 3'b000} +: 8] = byte_data;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and CPU reset decode; a captured byte takes priority over the
   // load_mode exit, which is then re-evaluated with the updated byte_idx.
   always_comb begin
      next_state = state;
      cpu_rst_n  = 1'b0;
      case (state)
         IDLE:  next_state = load_lvl ? LOAD : RUN;
         LOAD: begin
            if (capture) begin
               if (last_byte) next_state = WRITE;
            end else if (!load_lvl) begin
               next_state = (byte_idx != '0) ? FLUSH : RUN;
            end
         end
         WRITE: next_state = LOAD;
         FLUSH: next_state = RUN;
         RUN: begin
            cpu_rst_n = 1'b1;
            if (load_rise) next_state = LOAD;
         end
         default: next_state = IDLE;
      endcase
   end

   // Byte assembly, word pointer and registered memory write port; the write
   // is launched on the edge entering WRITE/FLUSH so it is valid in that state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx  <= '0;
         asm_q     <= '0;
         ptr       <= '0;
         overflow  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (enter_load) begin
            byte_idx <= '0;
            asm_q    <= '0;
            ptr      <= '0;
            overflow <= 1'b0;
         end
         if (capture) begin
            asm_q    <= word_next;
            byte_idx <= byte_idx + 1'b1;
         end
         if (emit && !full) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr[ADDR_W-1:0];
            mem_wdata <= word_next;
         end
         if ((state == WRITE) || (state == FLUSH)) begin
            if (!full) ptr <= ptr + 1'b1;
            else       overflow <= 1'b1;
            asm_q    <= '0;
            byte_idx <= '0;
         end
      end
   end

`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0] chk_q;

   // Running XOR of accepted bytes, cleared at the start of each session.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q <= '0;
      end else if (enter_load) begin
         chk_q <= '0;
      end else if (capture) begin
         chk_q <= chk_q ^ byte_data;
      end
   end

   assign checksum = chk_q;
`else
   assign checksum = '0;
`endif

endmodule
